// File: rtl/uart_pkg.sv
// Shared UART types and constants: line-format enums, TX state encoding
// and stop-bit durations expressed in baud ticks.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int STOP_TICKS_1    = 16;
  localparam int STOP_TICKS_1P5  = 24;
  localparam int STOP_TICKS_2    = 32;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'b00,
    STOP_1P5 = 2'b01,
    STOP_2   = 2'b10
  } stop_bits_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Stop duration in ticks, rescaled when a block uses a non-default oversample rate.
  function automatic int stop_ticks(input logic [1:0] sb, input int os);
    case (sb)
      STOP_1:   return STOP_TICKS_1 * os / OVERSAMPLE;
      STOP_1P5: return STOP_TICKS_1P5 * os / OVERSAMPLE;
      default:  return STOP_TICKS_2 * os / OVERSAMPLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: free-running 0..baud counter with a synchronous clear
// so a frame can align its bit edges to its own start.
module uart_baud_gen #(
  parameter int BAUD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [BAUD_W-1:0] baud,
  output logic              tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;

  // >= keeps a lowered divisor from wrapping the whole counter range.
  always_comb begin
    tick  = (cnt_q >= baud);
    cnt_d = cnt_q + BAUD_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: pops a fall-through FIFO and shifts out
// start, data (LSB first), optional parity and 1/1.5/2 stop bits.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int BAUD_W     = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [BAUD_W-1:0]    baud,
  input  logic [1:0]           parity_mode,
  input  logic [1:0]           stop_bits,
  input  logic                 tx_fifo_empty,
  input  logic [DATA_BITS-1:0] tx_fifo_rd_data,
  output logic                 tx_fifo_read_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);
  import uart_pkg::*;

  localparam int TICK_W = $clog2(2 * OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           par_q, par_d;
  logic [1:0]           stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 baud_clr, baud_tick, bit_end, pop;
  int                   limit;

  uart_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
    .clk   (clk),
    .rst_n (resetn),
    .clr   (baud_clr),
    .baud  (baud),
    .tick  (baud_tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_d      = par_q;
    stop_d     = stop_q;
    done_d     = 1'b0;
    baud_clr   = 1'b0;
    pop        = 1'b0;
    tx_d       = 1'b1;
    limit      = (state_q == STOP) ? stop_ticks(stop_q, OVERSAMPLE) : OVERSAMPLE;
    bit_end    = baud_tick && (tick_cnt_q == TICK_W'(limit - 1));

    if (state_q != IDLE && baud_tick)
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        // Gated by resetn so no pop strobe leaks out while reset is held.
        if (resetn && !tx_fifo_empty) begin
          pop       = 1'b1;
          data_d    = tx_fifo_rd_data;
          shift_d   = tx_fifo_rd_data;
          par_d     = parity_mode;
          stop_d    = stop_bits;
          bit_cnt_d = '0;
          baud_clr  = 1'b1;
          state_d   = START;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so it moves exactly on bit boundaries.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = (par_q == PAR_ODD) ? ~^data_q : ^data_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_q      <= '0;
      stop_q     <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign tx              = tx_q;
  assign tx_busy         = (state_q != IDLE);
  assign tx_done_tick    = done_q;
  assign tx_fifo_read_en = pop;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-computed frame
// expectations, a line monitor decodes tx and compares against them.
module tb_uart_tx;

  logic        clk;
  logic        resetn;
  logic [31:0] baud;
  logic [1:0]  parity_mode;
  logic [1:0]  stop_bits;
  logic        tx_fifo_empty;
  logic [7:0]  tx_fifo_rd_data;
  logic        tx_fifo_read_en;
  logic        tx;
  logic        tx_busy;
  logic        tx_done_tick;

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16), .BAUD_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .baud            (baud),
    .parity_mode     (parity_mode),
    .stop_bits       (stop_bits),
    .tx_fifo_empty   (tx_fifo_empty),
    .tx_fifo_rd_data (tx_fifo_rd_data),
    .tx_fifo_read_en (tx_fifo_read_en),
    .tx              (tx),
    .tx_busy         (tx_busy),
    .tx_done_tick    (tx_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       has_par;
    logic       par_bit;
    int         bitw;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   fall_cyc[$];
  int   done_cyc[$];
  int   rd_cyc[$];

  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int pops = 0;
  int done_pulses = 0;
  int frames_done = 0;
  int n_checks = 0;
  int n_pass = 0;

  assign tx_fifo_empty   = (wr_ptr == rd_ptr);
  assign tx_fifo_rd_data = fifo_mem[rd_ptr[3:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, expv, expv, cyc);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  task automatic add_exp(input logic [7:0] d, input logic hp, input logic pb,
                         input int bw, input int ln);
    exp_t e;
    e.data = d; e.has_par = hp; e.par_bit = pb; e.bitw = bw; e.len = ln;
    exp_q.push_back(e);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frames_done", frames_done, n);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (tx_done_tick) done_pulses++;
  end

  // FIFO model: pop the head just after the edge on which the DUT latched it.
  initial forever begin
    @(negedge clk);
    if (tx_fifo_read_en === 1'b1) begin
      pops++;
      rd_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      rd_ptr++;
    end
  end

  initial begin : monitor
    exp_t       e;
    int         t0, nb, tgt, n;
    logic [7:0] got;
    logic       stop_ok, busy_ok;
    forever begin
      while (exp_q.size() == 0) @(negedge clk);
      e = exp_q.pop_front();
      n = 0;
      while (tx !== 1'b0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (tx !== 1'b0) begin
        check("start_seen", {31'd0, tx}, 32'd0);
        continue;
      end
      t0 = cyc;
      fall_cyc.push_back(cyc);
      nb = e.has_par ? 10 : 9;
      busy_ok = 1'b1;
      got = '0;
      for (int k = 0; k < nb; k++) begin
        tgt = t0 + k * e.bitw + e.bitw / 2;
        while (cyc < tgt) @(negedge clk);
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
        if (k == 0)      check("start_bit", {31'd0, tx}, 32'd0);
        else if (k <= 8) got[k-1] = tx;
        else             check("parity_bit", {31'd0, tx}, {31'd0, e.par_bit});
      end
      check("data_byte", {24'd0, got}, {24'd0, e.data});
      tgt = t0 + nb * e.bitw;
      while (cyc < tgt) @(negedge clk);
      stop_ok = 1'b1;
      n = 0;
      while (tx_done_tick !== 1'b1 && n < 4000) begin
        if (tx !== 1'b1) stop_ok = 1'b0;
        if (tx_busy !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        n++;
      end
      check("done_offset", cyc - t0, e.len);
      check("stop_high", {31'd0, stop_ok}, 32'd1);
      check("busy_high", {31'd0, busy_ok}, 32'd1);
      done_cyc.push_back(cyc);
      frames_done++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int p0, d0, i0, n;
    logic idle_ok;
    for (int i = 0; i < 16; i++) fifo_mem[i] = '0;
    resetn = 1'b0; baud = 0; parity_mode = 2'b00; stop_bits = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, with a word already waiting in the FIFO.
    add_exp(8'hA5, 1'b0, 1'b0, 16, 160);
    push(8'hA5);
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    check("rst_read_en", {31'd0, tx_fifo_read_en}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    wait_frames(1, 400);
    check("single_pops", pops, 1);
    check("single_latency", fall_cyc[0] - rd_cyc[0], 1);

    // Parity: 0xA5 has four ones.
    @(posedge clk); #1;
    parity_mode = 2'b01;
    add_exp(8'hA5, 1'b1, 1'b0, 16, 176);
    push(8'hA5);
    wait_frames(2, 400);
    @(posedge clk); #1;
    parity_mode = 2'b10;
    add_exp(8'hA5, 1'b1, 1'b1, 16, 176);
    push(8'hA5);
    wait_frames(3, 400);

    // Divisor 3 with two and one-and-half stop bits.
    @(posedge clk); #1;
    parity_mode = 2'b00; baud = 3; stop_bits = 2'b10;
    add_exp(8'h00, 1'b0, 1'b0, 64, 704);
    push(8'h00);
    wait_frames(4, 1200);
    @(posedge clk); #1;
    stop_bits = 2'b01;
    add_exp(8'h00, 1'b0, 1'b0, 64, 672);
    push(8'h00);
    wait_frames(5, 1200);

    // Back-to-back frames.
    @(posedge clk); #1;
    baud = 0; stop_bits = 2'b00;
    i0 = rd_cyc.size();
    add_exp(8'h11, 1'b0, 1'b0, 16, 160);
    add_exp(8'h22, 1'b0, 1'b0, 16, 160);
    push(8'h11);
    push(8'h22);
    wait_frames(7, 800);
    check("b2b_pops", rd_cyc.size() - i0, 2);
    if (rd_cyc.size() >= i0 + 2)
      check("b2b_pop_gap", rd_cyc[i0+1] - rd_cyc[i0], 161);
    check("b2b_start_after_done", fall_cyc[6] - done_cyc[5], 1);

    // Empty FIFO: no pop, line idle.
    p0 = pops;
    idle_ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_ok = 1'b0;
    end
    check("empty_no_pop", pops, p0);
    check("empty_tx_idle", {31'd0, idle_ok}, 32'd1);

    // Mid-frame format change must not affect the frame in flight.
    @(posedge clk); #1;
    parity_mode = 2'b01; stop_bits = 2'b00;
    add_exp(8'hA5, 1'b1, 1'b0, 16, 176);
    push(8'hA5);
    repeat (50) @(posedge clk);
    #1;
    parity_mode = 2'b10; stop_bits = 2'b10;
    wait_frames(8, 400);

    // Reset during DATA: abort, then a clean frame afterwards.
    @(posedge clk); #1;
    parity_mode = 2'b00; stop_bits = 2'b00;
    d0 = done_pulses;
    push(8'h3C);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, tx_busy}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle_ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_ok = 1'b0;
    end
    check("midrst_no_done", done_pulses, d0);
    check("midrst_tx_idle", {31'd0, idle_ok}, 32'd1);
    @(posedge clk); #1;
    add_exp(8'h5A, 1'b0, 1'b0, 16, 160);
    push(8'h5A);
    wait_frames(9, 400);

    check("total_done_pulses", done_pulses, 9);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
